// File: rtl/spram32_arb.sv
// Two-port arbiter in front of the 32-bit x 32K single-port SPRAM, with lock for read-modify-write.
// Define SPRAM32_ARB_RR_EN for round-robin tie breaking; otherwise port 0 wins ties.
module spram32_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [14:0] ai0,
    input  logic [14:0] ai1,
    input  logic [31:0] vi0,
    input  logic [31:0] vi1,
    input  logic [3:0]  bmsk0,
    input  logic [3:0]  bmsk1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] vo0,
    output logic [31:0] vo1,
    output logic [14:0] ram_ai,
    output logic [31:0] ram_vi,
    output logic [3:0]  ram_bmsk,
    output logic        ram_we,
    input  logic [31:0] ram_vo,
    output logic [2:0]  dbg_state
);
    // Handshake: req_p is held until gnt_p is seen high in the same cycle; the
    // transfer happens in that cycle and ack_p pulses exactly once on the next.
    typedef enum logic [1:0] {
        OPEN    = 2'd0,
        LOCKED0 = 2'd1,
        LOCKED1 = 2'd2
    } lock_t;

    lock_t       lock_q, lock_d;
    logic        last_q;
    logic        rtag_v_q, rtag_p_q;
    logic [14:0] ai_q;
    logic [31:0] vi_q;
    logic [3:0]  bmsk_q;
    logic        grant;

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        lock_d = lock_q;
        case (lock_q)
            LOCKED0: gnt0 = req0;
            LOCKED1: gnt1 = req1;
            default: begin
                if (req0 && req1) begin
`ifdef SPRAM32_ARB_RR_EN
                    gnt0 = last_q;
                    gnt1 = ~last_q;
`else
                    gnt0 = 1'b1;
`endif
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
        grant = gnt0 | gnt1;
        // Idle cycles keep the lock; only a granted access can change it.
        if (gnt0)
            lock_d = lock0 ? LOCKED0 : OPEN;
        else if (gnt1)
            lock_d = lock1 ? LOCKED1 : OPEN;
    end

    // Bus holds its last driven values while idle to avoid toggling the macro pins.
    always_comb begin
        ram_ai   = ai_q;
        ram_vi   = vi_q;
        ram_bmsk = bmsk_q;
        ram_we   = 1'b0;
        if (gnt1) begin
            ram_ai   = ai1;
            ram_vi   = vi1;
            ram_bmsk = bmsk1;
            ram_we   = we1;
        end else if (gnt0) begin
            ram_ai   = ai0;
            ram_vi   = vi0;
            ram_bmsk = bmsk0;
            ram_we   = we0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q   <= OPEN;
            last_q   <= 1'b1;
            rtag_v_q <= 1'b0;
            rtag_p_q <= 1'b0;
            ai_q     <= '0;
            vi_q     <= '0;
            bmsk_q   <= '0;
        end else begin
            lock_q   <= lock_d;
            rtag_v_q <= grant;
            if (grant) begin
                last_q   <= gnt1;
                rtag_p_q <= gnt1;
                ai_q     <= ram_ai;
                vi_q     <= ram_vi;
                bmsk_q   <= ram_bmsk;
            end
        end
    end

    assign ack0      = rtag_v_q & ~rtag_p_q;
    assign ack1      = rtag_v_q & rtag_p_q;
    assign vo0       = ram_vo;
    assign vo1       = ram_vo;
    assign dbg_state = {last_q, lock_q};
endmodule

// File: tb/tb_spram32_arb.sv
// Directed bench for spram32_arb: vector table plus reset-abort sequence, with an SPRAM model.
module tb_spram32_arb;
    logic        clk, rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [14:0] ai0, ai1;
    logic [31:0] vi0, vi1;
    logic [3:0]  bmsk0, bmsk1;
    logic        gnt0, gnt1, ack0, ack1, ram_we;
    logic [31:0] vo0, vo1, ram_vi, ram_vo;
    logic [14:0] ram_ai;
    logic [3:0]  ram_bmsk;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    spram32_arb dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .ai0(ai0), .ai1(ai1), .vi0(vi0), .vi1(vi1),
        .bmsk0(bmsk0), .bmsk1(bmsk1), .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .vo0(vo0), .vo1(vo1),
        .ram_ai(ram_ai), .ram_vi(ram_vi), .ram_bmsk(ram_bmsk), .ram_we(ram_we),
        .ram_vo(ram_vo), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPRAM model: one-cycle read latency, byte-masked writes
    logic [31:0] mem [0:32767];
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        ram_vo = '0;
    end
    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_bmsk[b]) mem[ram_ai][b*8 +: 8] = ram_vi[b*8 +: 8];
        ram_vo <= mem[ram_ai];
    end

    typedef struct {
        logic        r0, r1, w0, w1, l0, l1;
        logic [14:0] a0, a1;
        logic [31:0] d0, d1;
        logic [3:0]  m0, m1;
        logic        eg0, eg1, ea0, ea1, chk_vo, ewe;
        logic [31:0] evo;
        logic [14:0] eai;
        logic [1:0]  elock;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [14:0] a0, input logic [31:0] d0,
        input logic [3:0] m0, input logic l0,
        input logic r1, input logic w1, input logic [14:0] a1, input logic [31:0] d1,
        input logic [3:0] m1, input logic l1,
        input logic eg0, input logic eg1, input logic ea0, input logic ea1,
        input logic chk_vo, input logic [31:0] evo, input logic ewe,
        input logic [14:0] eai, input logic [1:0] elock);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.m0 = m0; v.l0 = l0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.m1 = m1; v.l1 = l1;
        v.eg0 = eg0; v.eg1 = eg1; v.ea0 = ea0; v.ea1 = ea1;
        v.chk_vo = chk_vo; v.evo = evo; v.ewe = ewe; v.eai = eai; v.elock = elock;
        return v;
    endfunction

    // scoreboard check
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        ai0 = '0; ai1 = '0; vi0 = '0; vi1 = '0; bmsk0 = '0; bmsk1 = '0;
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; ai0 = v.a0; vi0 = v.d0; bmsk0 = v.m0; lock0 = v.l0;
        req1 = v.r1; we1 = v.w1; ai1 = v.a1; vi1 = v.d1; bmsk1 = v.m1; lock1 = v.l1;
    endtask

    initial begin
        //          r0 w0 a0       d0            m0  l0  r1 w1 a1       d1            m1  l1  g0 g1 a0 a1 cv evo           we ai       lk
        vt[0]  = mk(1, 1, 15'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 15'h0,   32'h0,        4'h0, 0, 1, 0, 0, 0, 0, 32'h0,        1, 15'h0010, 0);
        vt[1]  = mk(1, 0, 15'h0010, 32'h0,        4'h0, 0, 0, 0, 15'h0,   32'h0,        4'h0, 0, 1, 0, 1, 0, 0, 32'h0,        0, 15'h0010, 0);
        vt[2]  = mk(0, 0, 15'h0,    32'h0,        4'h0, 0, 1, 1, 15'h4010, 32'hDEADBEEF, 4'hF, 0, 0, 1, 1, 0, 1, 32'hDEADBEEF, 1, 15'h4010, 0);
        vt[3]  = mk(0, 0, 15'h0,    32'h0,        4'h0, 0, 1, 1, 15'h4010, 32'h12345678, 4'h3, 0, 0, 1, 0, 1, 0, 32'h0,        1, 15'h4010, 0);
        vt[4]  = mk(0, 0, 15'h0,    32'h0,        4'h0, 0, 1, 0, 15'h4010, 32'h0,        4'h0, 0, 0, 1, 0, 1, 0, 32'h0,        0, 15'h4010, 0);
        vt[5]  = mk(1, 0, 15'h0010, 32'h0,        4'h0, 0, 0, 0, 15'h0,   32'h0,        4'h0, 0, 1, 0, 0, 1, 1, 32'hDEAD5678, 0, 15'h0010, 0);
        vt[6]  = mk(0, 0, 15'h0,    32'h0,        4'h0, 0, 0, 0, 15'h0,   32'h0,        4'h0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF, 0, 15'h0010, 0);
        vt[7]  = mk(0, 0, 15'h0,    32'h0,        4'h0, 0, 1, 0, 15'h0030, 32'h0,        4'h0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 15'h0030, 0);
        vt[8]  = mk(1, 0, 15'h0020, 32'h0,        4'h0, 0, 1, 0, 15'h0030, 32'h0,        4'h0, 0, 1, 0, 0, 1, 1, 32'h0,        0, 15'h0020, 0);
`ifdef SPRAM32_ARB_RR_EN
        vt[9]  = mk(1, 0, 15'h0020, 32'h0,        4'h0, 0, 1, 0, 15'h0030, 32'h0,        4'h0, 0, 0, 1, 1, 0, 0, 32'h0,        0, 15'h0030, 0);
        vt[10] = mk(1, 0, 15'h0020, 32'h0,        4'h0, 0, 1, 0, 15'h0030, 32'h0,        4'h0, 0, 1, 0, 0, 1, 0, 32'h0,        0, 15'h0020, 0);
        vt[11] = mk(1, 0, 15'h0020, 32'h0,        4'h0, 0, 1, 0, 15'h0030, 32'h0,        4'h0, 0, 0, 1, 1, 0, 0, 32'h0,        0, 15'h0030, 0);
        vt[12] = mk(0, 0, 15'h0,    32'h0,        4'h0, 0, 0, 0, 15'h0,   32'h0,        4'h0, 0, 0, 0, 0, 1, 0, 32'h0,        0, 15'h0030, 0);
`else
        vt[9]  = mk(1, 0, 15'h0020, 32'h0,        4'h0, 0, 1, 0, 15'h0030, 32'h0,        4'h0, 0, 1, 0, 1, 0, 0, 32'h0,        0, 15'h0020, 0);
        vt[10] = mk(1, 0, 15'h0020, 32'h0,        4'h0, 0, 1, 0, 15'h0030, 32'h0,        4'h0, 0, 1, 0, 1, 0, 0, 32'h0,        0, 15'h0020, 0);
        vt[11] = mk(1, 0, 15'h0020, 32'h0,        4'h0, 0, 1, 0, 15'h0030, 32'h0,        4'h0, 0, 1, 0, 1, 0, 0, 32'h0,        0, 15'h0020, 0);
        vt[12] = mk(0, 0, 15'h0,    32'h0,        4'h0, 0, 0, 0, 15'h0,   32'h0,        4'h0, 0, 0, 0, 1, 0, 0, 32'h0,        0, 15'h0020, 0);
`endif
        vt[13] = mk(0, 0, 15'h0,    32'h0,        4'h0, 0, 1, 0, 15'h0100, 32'h0,        4'h0, 1, 0, 1, 0, 0, 0, 32'h0,        0, 15'h0100, 0);
        vt[14] = mk(1, 0, 15'h0010, 32'h0,        4'h0, 0, 1, 0, 15'h0100, 32'h0,        4'h0, 1, 0, 1, 0, 1, 0, 32'h0,        0, 15'h0100, 2);
        vt[15] = mk(1, 0, 15'h0010, 32'h0,        4'h0, 0, 0, 0, 15'h0,   32'h0,        4'h0, 0, 0, 0, 0, 1, 0, 32'h0,        0, 15'h0100, 2);
        vt[16] = mk(1, 0, 15'h0010, 32'h0,        4'h0, 0, 1, 1, 15'h0100, 32'hCAFEF00D, 4'hF, 0, 0, 1, 0, 0, 0, 32'h0,        1, 15'h0100, 2);
        vt[17] = mk(1, 0, 15'h0010, 32'h0,        4'h0, 0, 0, 0, 15'h0,   32'h0,        4'h0, 0, 1, 0, 0, 1, 0, 32'h0,        0, 15'h0010, 0);
        vt[18] = mk(0, 0, 15'h0,    32'h0,        4'h0, 0, 0, 0, 15'h0,   32'h0,        4'h0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF, 0, 15'h0010, 0);

        // reset state
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("rst gnt0", {31'b0, gnt0}, 32'h0);
        check("rst gnt1", {31'b0, gnt1}, 32'h0);
        check("rst ack",  {30'b0, ack0, ack1}, 32'h0);
        check("rst ram_we", {31'b0, ram_we}, 32'h0);
        check("rst ram_ai", {17'b0, ram_ai}, 32'h0);
        check("rst ram_vi", ram_vi, 32'h0);
        check("rst ram_bmsk", {28'b0, ram_bmsk}, 32'h0);
        check("rst state", {29'b0, dbg_state}, 32'h4);
        @(posedge clk); #1;
        rst = 1'b0;

        // vector table
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            drive(vt[i]);
            @(negedge clk);
            check($sformatf("v%0d gnt0", i), {31'b0, gnt0}, {31'b0, vt[i].eg0});
            check($sformatf("v%0d gnt1", i), {31'b0, gnt1}, {31'b0, vt[i].eg1});
            check($sformatf("v%0d ack0", i), {31'b0, ack0}, {31'b0, vt[i].ea0});
            check($sformatf("v%0d ack1", i), {31'b0, ack1}, {31'b0, vt[i].ea1});
            check($sformatf("v%0d ram_we", i), {31'b0, ram_we}, {31'b0, vt[i].ewe});
            check($sformatf("v%0d ram_ai", i), {17'b0, ram_ai}, {17'b0, vt[i].eai});
            check($sformatf("v%0d lock", i), {30'b0, dbg_state[1:0]}, {30'b0, vt[i].elock});
            if (vt[i].chk_vo)
                check($sformatf("v%0d vo", i), vt[i].ea0 ? vo0 : vo1, vt[i].evo);
        end

        // reset one cycle after a locked read grant
        @(posedge clk); #1;
        idle_inputs();
        req0 = 1; ai0 = 15'h0010; lock0 = 1;
        @(negedge clk);
        check("abort gnt0", {31'b0, gnt0}, 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        #1;
        check("abort ack0", {31'b0, ack0}, 32'h0);
        check("abort ack1", {31'b0, ack1}, 32'h0);
        check("abort lock", {30'b0, dbg_state[1:0]}, 32'h0);
        @(posedge clk); #1;
        check("abort ack held", {30'b0, ack0, ack1}, 32'h0);
        rst = 1'b0;
        req0 = 1; req1 = 1; ai0 = 15'h0020; ai1 = 15'h0030;
        @(negedge clk);
        check("post-rst gnt0", {31'b0, gnt0}, 32'h1);
        check("post-rst gnt1", {31'b0, gnt1}, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("post-rst ack0", {31'b0, ack0}, 32'h1);
        check("post-rst ack1", {31'b0, ack1}, 32'h0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
